// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master sequencer in front of a single-port sync RAM,
// returning read data to the owning master two cycles after its grant.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout
);
  logic last_winner, tag_v, tag_o, elig0, elig1, win1, any;
  // a request seen during its own grant cycle is stale, so it cannot win again
  always_comb begin
    elig0 = m0_req & ~m0_gnt;
    elig1 = m1_req & ~m1_gnt;
    win1  = elig1 & (~elig0 | ~last_winner);
    any   = elig0 | elig1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      cen         <= 1'b0;
      wen         <= 1'b0;
      s_addr      <= '0;
      s_din       <= '0;
      last_winner <= 1'b1;
      tag_v       <= 1'b0;
      tag_o       <= 1'b0;
    end else begin
      m0_gnt <= any & ~win1;
      m1_gnt <= win1;
      cen    <= any;
      wen    <= any & (win1 ? m1_wr : m0_wr);
      if (any) begin
        s_addr      <= win1 ? m1_addr : m0_addr;
        s_din       <= win1 ? m1_wdata : m0_wdata;
        last_winner <= win1;
      end
      // tag follows the access through the RAM so data lands with its owner
      tag_v     <= cen & ~wen;
      tag_o     <= m1_gnt;
      m0_rvalid <= tag_v & ~tag_o;
      m1_rvalid <= tag_v & tag_o;
      if (tag_v & ~tag_o) m0_rdata <= s_dout;
      if (tag_v & tag_o) m1_rdata <= s_dout;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a queue scoreboard for read returns,
// driving a behavioural 256x64 sync RAM attached to the arbiter.
module tb_ram_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [7:0]  m0_addr = 0, m1_addr = 0, s_addr;
  logic [63:0] m0_wdata = 0, m1_wdata = 0, m0_rdata, m1_rdata, s_din, s_dout;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, cen, wen;
  logic [63:0] mem [256];
  int          cyc = 0, checks = 0, errors = 0;
  typedef struct { logic [63:0] d; int c; } exp_t;
  exp_t q0 [$], q1 [$];
  localparam logic [63:0] D1 = 64'hDEADBEEF00000001, D2 = 64'h0123456789ABCDEF;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // RAM returns 0 on write cycles
  always @(posedge clk)
    if (cen) begin
      if (wen) begin
        mem[s_addr] <= s_din;
        s_dout      <= '0;
      end else s_dout <= mem[s_addr];
    end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic push(input bit m, input logic [63:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 2;
    if (m) q1.push_back(e); else q0.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0_rvalid) begin
      if (q0.size() == 0) chk("m0_rvalid_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("m0_rdata", m0_rdata, e.d);
        chk("m0_latency", cyc, e.c);
      end
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) chk("m1_rvalid_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("m1_rdata", m1_rdata, e.d);
        chk("m1_latency", cyc, e.c);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, cen, wen}, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    chk("rst_addr_din", s_addr | s_din, 0);
    reset = 1'b0;
    // both masters write together: m0 wins the first tie
    m0_req = 1; m0_wr = 1; m0_addr = 8'h10; m0_wdata = D1;
    m1_req = 1; m1_wr = 1; m1_addr = 8'h20; m1_wdata = D2;
    @(negedge clk);
    chk("wr_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("wr_pins", {cen, wen, s_addr}, {2'b11, 8'h10});
    chk("wr_din", s_din, D1);
    m0_req = 0;
    @(negedge clk);
    chk("wr1_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("wr1_pins", {cen, wen, s_addr}, {2'b11, 8'h20});
    chk("wr1_din", s_din, D2);
    m1_req = 0;
    @(negedge clk);
    chk("idle_hold", {cen, wen, s_addr}, {2'b00, 8'h20});
    chk("idle_din", s_din, D2);
    // m0 reads back its write
    m0_req = 1; m0_wr = 0;
    @(negedge clk);
    chk("rd_gnt", {m0_gnt, m1_gnt, cen, wen, s_addr}, {4'b1010, 8'h10});
    push(0, D1);
    m0_req = 0;
    repeat (3) @(negedge clk);
    // lone m1 read request: grant every other cycle
    m1_req = 1; m1_wr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("solo_gnt", {m0_gnt, m1_gnt, cen}, (i % 2 == 0) ? 3'b011 : 3'b000);
      if (i % 2 == 0) push(1, D2);
    end
    // both hold reads: strict alternation starting with m0, RAM busy every cycle
    m0_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_gnt", {m0_gnt, m1_gnt, cen}, (i % 2 == 0) ? 3'b101 : 3'b011);
      chk("rr_addr", s_addr, (i % 2 == 0) ? 8'h10 : 8'h20);
      push(i % 2 == 1, (i % 2 == 0) ? D1 : D2);
    end
    m0_req = 0; m1_req = 0;
    repeat (4) @(negedge clk);
    // reset right after a read grant: the read must vanish
    m0_req = 1;
    @(negedge clk);
    chk("pre_rst_gnt", {m0_gnt, cen}, 2'b11);
    m0_req = 0; reset = 1'b1;
    #1;
    chk("async_rst", {m0_gnt, cen, wen}, 0);
    @(negedge clk);
    chk("rst_rdata_clr", m0_rdata | m1_rdata, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_rvalid", {m0_rvalid, m1_rvalid, m0_rdata != 0, m1_rdata != 0}, 0);
    chk("q_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
